// File: rtl/exec_sequencer.sv
// Instruction-execution sequencer: steps each instruction through issue, optional
// read/write memory phases with wait-state and ready-timeout handling, then retire.
//
// state   | meaning
// --------+-----------------------------------------------------------
// STOPPED | idle; waits for a step rising edge
// ISSUE   | latch decoded read/write needs, pick first phase
// READ    | memory read: wait-state countdown, then wait for mem_ready
// WRITE   | memory write: wait-state countdown, then wait for mem_ready
// RETIRE  | advance PC, count instruction, continue or stop
module exec_sequencer #(
   parameter int CNT_W      = 4,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 1,
   parameter int TIMEOUT    = 15,
   parameter int RET_W      = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             run_mode,
   input  logic             step,
   input  logic             halt_req,
   input  logic             needs_read,
   input  logic             needs_write,
   input  logic             mem_ready,
   output logic             pc_increment,
   output logic             load_enable,
   output logic             store_enable,
   output logic             mem_read_req,
   output logic             mem_write_req,
   output logic             running,
   output logic             fault,
   output logic [2:0]       state,
   output logic [RET_W-1:0] retired_count
);

   typedef enum logic [2:0] {
      ST_STOPPED = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_READ    = 3'd2,
      ST_WRITE   = 3'd3,
      ST_RETIRE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RD_WAIT  = CNT_W'(READ_WAIT);
   localparam logic [CNT_W-1:0] WR_WAIT  = CNT_W'(WRITE_WAIT);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           st;
   state_t           nxt;
   logic             step_q;
   logic             halt_pending;
   logic             op_rd;
   logic             op_wr;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] tmo_cnt;

   logic step_rise;
   logic in_mem;
   logic rd_done;
   logic wr_done;
   logic tmo_hit;

   assign step_rise = step & ~step_q;
   assign in_mem    = (st == ST_READ) || (st == ST_WRITE);
   // Completion strobes depend on mem_ready in the same cycle, so they are
   // decoded from the registered state rather than registered themselves.
   assign rd_done   = (st == ST_READ) && op_rd && (wait_cnt == '0) && mem_ready;
   assign wr_done   = (st == ST_WRITE) && (wait_cnt == '0) && mem_ready;
   assign tmo_hit   = in_mem && (wait_cnt == '0) && !mem_ready && (tmo_cnt == TMO_LAST);

   assign load_enable  = rd_done;
   assign store_enable = wr_done;
   assign state        = st;

   always_comb begin
      nxt = st;
      case (st)
         ST_STOPPED: if (step_rise) nxt = ST_ISSUE;
         ST_ISSUE: begin
            if (needs_read)       nxt = ST_READ;
            else if (needs_write) nxt = ST_WRITE;
            else                  nxt = ST_RETIRE;
         end
         ST_READ: begin
            if (rd_done)      nxt = op_wr ? ST_WRITE : ST_RETIRE;
            else if (tmo_hit) nxt = ST_STOPPED;
         end
         ST_WRITE: begin
            if (wr_done)      nxt = ST_RETIRE;
            else if (tmo_hit) nxt = ST_STOPPED;
         end
         ST_RETIRE: begin
            if (halt_pending || halt_req || !run_mode) nxt = ST_STOPPED;
            else                                       nxt = ST_ISSUE;
         end
         default: nxt = ST_STOPPED;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         st            <= ST_STOPPED;
         step_q        <= 1'b0;
         halt_pending  <= 1'b0;
         op_rd         <= 1'b0;
         op_wr         <= 1'b0;
         wait_cnt      <= '0;
         tmo_cnt       <= '0;
         fault         <= 1'b0;
         retired_count <= '0;
         pc_increment  <= 1'b0;
         mem_read_req  <= 1'b0;
         mem_write_req <= 1'b0;
         running       <= 1'b0;
      end else begin
         st            <= nxt;
         step_q        <= step;
         running       <= (nxt != ST_STOPPED);
         mem_read_req  <= (nxt == ST_READ);
         mem_write_req <= (nxt == ST_WRITE);
         pc_increment  <= (nxt == ST_RETIRE);

         // A halt seen together with the starting step still lets one instruction run.
         if (st == ST_STOPPED) begin
            if (step_rise) halt_pending <= halt_req;
         end else if (halt_req) begin
            halt_pending <= 1'b1;
         end

         if ((st == ST_STOPPED) && step_rise) fault <= 1'b0;
         else if (tmo_hit)                    fault <= 1'b1;

         if (st == ST_RETIRE) retired_count <= retired_count + 1'b1;

         if (st == ST_ISSUE) begin
            op_rd    <= needs_read;
            op_wr    <= needs_write;
            wait_cnt <= needs_read ? RD_WAIT : WR_WAIT;
            tmo_cnt  <= '0;
         end else if (rd_done && op_wr) begin
            wait_cnt <= WR_WAIT;
            tmo_cnt  <= '0;
         end else if (in_mem) begin
            if (wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;
            else if (!mem_ready) tmo_cnt  <= tmo_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: one instance with wait states and a short
// timeout, one with zero wait states for latency checks.
module tb_exec_sequencer;

   logic clock = 1'b0;
   logic resetn, run_mode, step, halt_req, needs_read, needs_write, mem_ready;

   logic       pc_increment, load_enable, store_enable, mem_read_req, mem_write_req;
   logic       running, fault;
   logic [2:0] state;
   logic [3:0] retired_count;

   logic        pc_increment0, load_enable0, store_enable0, mem_read_req0, mem_write_req0;
   logic        running0, fault0;
   logic [2:0]  state0;
   logic [15:0] retired_count0;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses;

   always #5 clock = ~clock;

   exec_sequencer #(.CNT_W(4), .READ_WAIT(2), .WRITE_WAIT(1), .TIMEOUT(3), .RET_W(4)) dut (
      .clock(clock), .resetn(resetn), .run_mode(run_mode), .step(step), .halt_req(halt_req),
      .needs_read(needs_read), .needs_write(needs_write), .mem_ready(mem_ready),
      .pc_increment(pc_increment), .load_enable(load_enable), .store_enable(store_enable),
      .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .running(running),
      .fault(fault), .state(state), .retired_count(retired_count)
   );

   exec_sequencer #(.CNT_W(4), .READ_WAIT(0), .WRITE_WAIT(0), .TIMEOUT(15), .RET_W(16)) dut0 (
      .clock(clock), .resetn(resetn), .run_mode(run_mode), .step(step), .halt_req(halt_req),
      .needs_read(needs_read), .needs_write(needs_write), .mem_ready(mem_ready),
      .pc_increment(pc_increment0), .load_enable(load_enable0), .store_enable(store_enable0),
      .mem_read_req(mem_read_req0), .mem_write_req(mem_write_req0), .running(running0),
      .fault(fault0), .state(state0), .retired_count(retired_count0)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      step        = 1'b0;
      halt_req    = 1'b0;
      needs_read  = 1'b0;
      needs_write = 1'b0;
      mem_ready   = 1'b1;
      run_mode    = 1'b1;
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; run_mode = 1'b1; step = 1'b0; halt_req = 1'b0;
      needs_read = 1'b0; needs_write = 1'b0; mem_ready = 1'b1;
      tick();
      do_reset();
      check("rst_state", 32'(state), 32'd0);
      check("rst_retired", 32'(retired_count), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_pc", 32'(pc_increment), 32'd0);

      // free run, no memory ops
      step = 1'b1;
      tick();
      check("fr_issue", 32'(state), 32'd1);
      check("fr_running", 32'(running), 32'd1);
      for (int i = 1; i <= 10; i++) begin
         tick();
         check($sformatf("fr_pc%0d", i), 32'(pc_increment), 32'(i % 2));
      end
      check("fr_retired5", 32'(retired_count), 32'd5);
      check("fr_state_issue", 32'(state), 32'd1);
      run_mode = 1'b0;
      tick();
      tick();
      check("fr_stop_state", 32'(state), 32'd0);
      check("fr_stop_retired", 32'(retired_count), 32'd6);
      check("fr_z_retired", 32'(retired_count0), 32'd6);

      // read + write, one instruction; dut0 shows the zero-wait 4-cycle latency
      do_reset();
      run_mode = 1'b0; needs_read = 1'b1; needs_write = 1'b1;
      step = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("rw_ld%0d", i), 32'(load_enable), 32'(i == 3));
         check($sformatf("rw_st%0d", i), 32'(store_enable), 32'(i == 5));
         check($sformatf("rw_pc%0d", i), 32'(pc_increment), 32'(i == 6));
         if (i <= 3) begin
            check($sformatf("z_ld%0d", i), 32'(load_enable0), 32'(i == 1));
            check($sformatf("z_st%0d", i), 32'(store_enable0), 32'(i == 2));
            check($sformatf("z_pc%0d", i), 32'(pc_increment0), 32'(i == 3));
         end
         if (i == 1) check("rw_rdreq", 32'(mem_read_req), 32'd1);
         if (i == 4) check("rw_wrreq", 32'(mem_write_req), 32'd1);
      end
      tick();
      check("rw_stopped", 32'(state), 32'd0);
      check("rw_retired", 32'(retired_count), 32'd1);

      // single step with step held high
      do_reset();
      run_mode = 1'b0;
      step = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pc_increment) pulses++;
      end
      check("ss_pulses", 32'(pulses), 32'd1);
      check("ss_retired1", 32'(retired_count), 32'd1);
      check("ss_state", 32'(state), 32'd0);
      step = 1'b0;
      tick();
      step = 1'b1;
      repeat (3) tick();
      check("ss_retired2", 32'(retired_count), 32'd2);
      check("ss_state2", 32'(state), 32'd0);

      // read timeout
      do_reset();
      run_mode = 1'b0; needs_read = 1'b1; mem_ready = 1'b0;
      step = 1'b1;
      tick();
      check("to_issue", 32'(state), 32'd1);
      pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (pc_increment || load_enable) pulses++;
         check($sformatf("to_state%0d", i), 32'(state), (i < 6) ? 32'd2 : 32'd0);
         check($sformatf("to_fault%0d", i), 32'(fault), 32'(i == 6));
      end
      check("to_no_pulse", 32'(pulses), 32'd0);
      check("to_retired", 32'(retired_count), 32'd0);
      tick();
      check("to_sticky", 32'(fault), 32'd1);
      mem_ready = 1'b1; needs_read = 1'b0; step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      check("to_clear", 32'(fault), 32'd0);
      check("to_restart", 32'(state), 32'd1);

      // deferred halt during WRITE
      do_reset();
      run_mode = 1'b1; needs_write = 1'b1;
      step = 1'b1;
      tick();
      tick();
      check("dh_write", 32'(state), 32'd3);
      check("dh_st0", 32'(store_enable), 32'd0);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("dh_st1", 32'(store_enable), 32'd1);
      tick();
      check("dh_retire", 32'(state), 32'd4);
      check("dh_pc", 32'(pc_increment), 32'd1);
      tick();
      check("dh_stopped", 32'(state), 32'd0);
      check("dh_retired", 32'(retired_count), 32'd1);
      tick();
      check("dh_stays", 32'(state), 32'd0);

      // halt and step together in STOPPED
      do_reset();
      run_mode = 1'b1;
      halt_req = 1'b1; step = 1'b1;
      tick();
      halt_req = 1'b0;
      check("hs_issue", 32'(state), 32'd1);
      tick();
      tick();
      check("hs_stopped", 32'(state), 32'd0);
      check("hs_retired", 32'(retired_count), 32'd1);
      tick();
      check("hs_stays", 32'(state), 32'd0);

      // reset in the middle of READ
      do_reset();
      run_mode = 1'b1;
      step = 1'b1;
      repeat (5) tick();
      needs_read = 1'b1;
      tick();
      check("mr_read", 32'(state), 32'd2);
      check("mr_pre_retired", 32'(retired_count), 32'd2);
      resetn = 1'b0;
      tick();
      check("mr_state", 32'(state), 32'd0);
      check("mr_retired", 32'(retired_count), 32'd0);
      check("mr_load", 32'(load_enable), 32'd0);
      check("mr_rdreq", 32'(mem_read_req), 32'd0);
      resetn = 1'b1;

      // retired counter wrap
      do_reset();
      run_mode = 1'b1;
      step = 1'b1;
      tick();
      repeat (30) tick();
      check("wr_15", 32'(retired_count), 32'd15);
      repeat (2) tick();
      check("wr_wrap", 32'(retired_count), 32'd0);
      check("wr_z_16", 32'(retired_count0), 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Parametrised instruction-execution sequencer. It is the next generation of the processor's control-path state machine.
- Replaces the fixed one-cycle read/write wait states with configurable wait-state counters and a memory-ready handshake with timeout.
- Adds run and single-step modes, a deferred halt request, and a retired-instruction counter.
- Sits between the instruction decoder, the program counter and the memory/stack interface.

Parameters:
CNT_W, 4, width of the wait/timeout counter.
READ_WAIT, 1, minimum cycles in READ before mem_ready is sampled (0..2^CNT_W-1).
WRITE_WAIT, 1, minimum cycles in WRITE before mem_ready is sampled (0..2^CNT_W-1).
TIMEOUT, 15, cycles allowed after the wait expires for mem_ready before faulting (1..2^CNT_W-1).
RET_W, 16, width of retired_count.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
resetn  in  1  reset, synchronous, active-low.
run_mode  in  1  1 = free run; 0 = single-step (one instruction per step edge).
step  in  1  user step/start level (debounced upstream); rising edge detected internally.
halt_req  in  1  request to stop after the current instruction retires.
needs_read  in  1  decoded instruction loads from memory/stack; sampled in ISSUE only.
needs_write  in  1  decoded instruction stores to memory/stack; sampled in ISSUE only.
mem_ready  in  1  memory interface ready/ack.
pc_increment  out  1  one-cycle pulse in RETIRE.
load_enable  out  1  one-cycle pulse on the READ completion cycle.
store_enable  out  1  one-cycle pulse on the WRITE completion cycle.
mem_read_req  out  1  high throughout READ.
mem_write_req  out  1  high throughout WRITE.
running  out  1  high in every state except STOPPED.
fault  out  1  sticky timeout flag.
state  out  3  current state encoding.
retired_count  out  RET_W  count of retired instructions; wraps modulo 2^RET_W.

Behaviour:
- Reset: resetn low at a rising edge forces the following, regardless of the current state; an in-flight access is abandoned with no pulse:
  - state=STOPPED (0);
  - all pulses and requests 0;
  - fault=0, retired_count=0, halt_pending=0, step_q=0.
- Step edge: step_q registers step each cycle; step_rise = step & ~step_q.
- States: STOPPED=0, ISSUE=1, READ=2, WRITE=3, RETIRE=4; encodings 5-7 go to STOPPED next cycle.
- STOPPED: on step_rise go to ISSUE and clear fault and halt_pending. Otherwise stay.
- ISSUE (1 cycle): latch op_rd=needs_read and op_wr=needs_write. Next state is READ if op_rd, else WRITE if op_wr, else RETIRE. Load the counter with READ_WAIT or WRITE_WAIT accordingly.
- READ:
  - Counter decrements each cycle while nonzero.
  - Once at 0, mem_ready is sampled. If mem_ready=1: load_enable=1 that cycle, and next state is WRITE (counter=WRITE_WAIT) if op_wr, else RETIRE.
  - If mem_ready=0: a timeout counter counts. When it reaches TIMEOUT, set fault=1 and go to STOPPED with no pulse and no retire.
- WRITE: same rules as READ, using store_enable; on success go to RETIRE.
- The wait-0 case allows a completion in the first cycle of READ or WRITE when mem_ready=1.
- RETIRE (1 cycle):
  - pc_increment=1 and retired_count+1.
  - Next state is STOPPED if halt_pending, halt_req or ~run_mode; else ISSUE.
- halt_req asserted in any running state sets halt_pending. An instruction is never aborted by halt_req.
- Simultaneous events: halt_req and step_rise both in STOPPED → go to ISSUE, execute exactly one instruction, then stop.
- Latency: with READ_WAIT=WRITE_WAIT=0 and mem_ready held 1:
  - no-memory instruction = 2 cycles;
  - read-only = 3 cycles;
  - read+write = 4 cycles.
- fault stays 1 until reset or the next step_rise.

Test Plan:
- Free run, no memory ops, run_mode=1, mem_ready=1: step pulse → ISSUE/RETIRE alternate; pc_increment every 2nd cycle; retired_count=5 after 10 cycles.
- Read+write, READ_WAIT=2, WRITE_WAIT=1, mem_ready=1 → load_enable 3 cycles after ISSUE and store_enable 2 cycles later; pc_increment next cycle; 7 cycles total per instruction.
- Single-step, run_mode=0: hold step high for 20 cycles → exactly one retire; retired_count=1; state returns to 0; a second rising edge → retired_count=2.
- Timeout, TIMEOUT=3, needs_read=1, mem_ready=0 → fault=1 and state=STOPPED after READ_WAIT+3 cycles in READ; no pc_increment; step_rise clears fault.
- Deferred halt: halt_req pulses during WRITE → store_enable and pc_increment still occur, then STOPPED.
- Reset mid-READ: resetn low 1 cycle → state=0, retired_count=0, no load_enable; retired_count wraps 0xFFFF→0 with RET_W=16.
